legv8_multicycle_ctrl: RTL and testbench
========================================

Name: legv8_multicycle_ctrl

Overview:
Multi-cycle control FSM for the LEGv8 subset datapath (ADD, SUB, AND, ORR, LDUR, STUR, CBZ). It sequences fetch, decode, execute, memory and writeback over a shared ALU and a single unified memory port. It drives the 2-bit ALUOp into the existing ALU-control decoder (00 = D-type add, 01 = CBZ pass/zero-test, 10 = R-type funct decode). It sits between the instruction register and the datapath mux/enable signals.

Parameters:
MEM_TIMEOUT, 15, max cycles to wait for mem_ready before flagging mem_err (0 disables the timeout)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
opcode  in  11  instruction register bits [31:21]
zero  in  1  ALU zero flag (valid in BRANCH state)
mem_ready  in  1  memory completes the current request this cycle
pc_write  out  1  unconditional PC update
pc_src  out  1  0 = PC+4, 1 = branch target
ir_write  out  1  load instruction register
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read (qualified by mem_req)
i_or_d  out  1  memory address: 0 = PC, 1 = ALU result register
reg_write  out  1  register-file write enable
mem_to_reg  out  1  writeback source: 0 = ALU out, 1 = MDR
reg2loc  out  1  read-port-2 select: 0 = Rm[20:16], 1 = Rt[4:0]
alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sign-extended offset, 11 = branch offset <<2
alu_op  out  2  to ALU-control decoder
illegal  out  1  sticky: unsupported opcode decoded
mem_err  out  1  sticky: memory timeout
state_o  out  4  current state encoding (debug)

Behaviour:
- States (encoding in package): FETCH=0, DECODE=1, EXEC_R=2, ADDR=3, MEM_RD=4, MEM_WR=5, WB_R=6, WB_LD=7, BRANCH=8, HALT=9.
- Reset: state = FETCH, wait counter = 0, illegal = 0, mem_err = 0. All outputs are Moore-decoded from state and are 0 except where listed per state.
- FETCH: mem_req=1, mem_we=0, i_or_d=0, alu_src_b=01, alu_op=00. While mem_ready=0, hold and increment the wait counter. On mem_ready=1: ir_write=1, pc_write=1, pc_src=0, go to DECODE. The ir_write/pc_write pulse is Mealy, gated by mem_ready, and lasts exactly one cycle.
- DECODE: alu_src_b=11, alu_op=00 (precompute branch target). Decoding uses exact match:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC_R
  - LDUR 11111000010, STUR 11111000000 -> ADDR
  - opcode[10:3]=10110100 (CBZ) -> BRANCH
  - anything else -> set illegal, go to HALT
  - reg2loc=1 for STUR and CBZ, 0 otherwise.
- EXEC_R: alu_src_b=00, alu_op=10 -> WB_R.
- WB_R: reg_write=1, mem_to_reg=0 -> FETCH.
- ADDR: alu_src_b=10, alu_op=00. Go to MEM_RD if opcode[1]=1 (LDUR), else MEM_WR.
- MEM_RD: mem_req=1, mem_we=0, i_or_d=1. Wait for mem_ready, then go to WB_LD.
- WB_LD: reg_write=1, mem_to_reg=1 -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, i_or_d=1, reg2loc=1. Wait for mem_ready, then go to FETCH.
- BRANCH: alu_src_b=00, alu_op=01, reg2loc=1. pc_write=zero, pc_src=1 -> FETCH.
- HALT: all enables 0. Only reset exits HALT.
- Handshake rules:
  - mem_req and the address/write controls stay stable until the mem_ready cycle.
  - mem_ready is ignored when mem_req=0.
  - The wait counter clears on every state transition.
- Timeout: if MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT while still waiting, set mem_err and go to HALT. No writes occur on that cycle.
- Latency with mem_ready tied high:
  - R-type = 4 cycles (FETCH, DECODE, EXEC_R, WB_R)
  - LDUR = 5 cycles
  - STUR = 4 cycles
  - CBZ = 3 cycles
- Reset mid-operation: reset wins over every transition, including a same-cycle mem_ready. There is no pending write after reset.
- The Rt/Rn/Rm register fields are not used by the controller. The opcode must stay stable from DECODE until return to FETCH, which is guaranteed because the IR is written only in FETCH.

Decomposition:
- Package legv8_ctrl_pkg: state enum/localparams, the seven opcode constants, the CBZ 8-bit prefix, ALUOp codes (ALUOP_DTYPE=00, ALUOP_CBZ=01, ALUOP_RTYPE=10), alu_src_b codes.
- Sub-module legv8_opcode_decode (combinational): opcode -> {is_r, is_ld, is_st, is_cbz, illegal}. This sub-module is shared with the ALU-control decoder's checks.

Test Plan:
- ADD opcode 10001011000, mem_ready=1 -> states 0,1,2,6,0; alu_op=10 in EXEC_R; reg_write=1 only in cycle 4; pc_write one pulse in cycle 1.
- LDUR 11111000010, mem_ready delayed 3 cycles in MEM_RD -> mem_req=1, i_or_d=1 held 4 cycles; WB_LD has mem_to_reg=1, reg_write=1; total 8 cycles.
- STUR 11111000000 -> MEM_WR has mem_we=1, reg2loc=1; reg_write never asserted.
- CBZ 10110100xxx with zero=1 -> BRANCH has pc_write=1, pc_src=1. Repeat with zero=0 -> pc_write=0.
- Opcode 00000000000 -> illegal=1, state HALT, stays there 20 cycles; reset -> FETCH, illegal=0.
- MEM_TIMEOUT=15 with mem_ready=0 in FETCH -> mem_err=1 after 15 cycles, HALT. Separately, reset asserted in MEM_WR with mem_ready=1 -> next state FETCH.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// rtl/legv8_ctrl_pkg.sv - shared encodings for the LEGv8 multi-cycle controller
package legv8_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_ADDR   = 4'd3,
      S_MEM_RD = 4'd4,
      S_MEM_WR = 4'd5,
      S_WB_R   = 4'd6,
      S_WB_LD  = 4'd7,
      S_BRANCH = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100000;

   // CBZ carries part of its immediate in opcode[2:0], so only the prefix is matched
   localparam logic [7:0] OP_CBZ_PFX = 8'b10110100;

   localparam logic [1:0] ALUOP_DTYPE = 2'b00;
   localparam logic [1:0] ALUOP_CBZ   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_OFFS = 2'b10;
   localparam logic [1:0] SRCB_BR   = 2'b11;

endpackage

// File: rtl/legv8_opcode_decode.sv
// rtl/legv8_opcode_decode.sv - classifies an 11-bit LEGv8 opcode into instruction groups
module legv8_opcode_decode
   import legv8_ctrl_pkg::*;
(
   input  logic [10:0] opcode_i,
   output logic        is_r_o,
   output logic        is_ld_o,
   output logic        is_st_o,
   output logic        is_cbz_o,
   output logic        illegal_o
);

   always_comb begin
      is_r_o    = (opcode_i == OP_ADD) || (opcode_i == OP_SUB) ||
                  (opcode_i == OP_AND) || (opcode_i == OP_ORR);
      is_ld_o   = (opcode_i == OP_LDUR);
      is_st_o   = (opcode_i == OP_STUR);
      is_cbz_o  = (opcode_i[10:3] == OP_CBZ_PFX);
      illegal_o = !(is_r_o || is_ld_o || is_st_o || is_cbz_o);
   end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// rtl/legv8_multicycle_ctrl.sv - multi-cycle control FSM for the LEGv8 subset datapath
module legv8_multicycle_ctrl
   import legv8_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_src,
   output logic        ir_write,
   output logic        mem_req,
   output logic        mem_we,
   output logic        i_or_d,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        reg2loc,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        illegal,
   output logic        mem_err,
   output logic [3:0]  state_o
);

   localparam int WAIT_W = 16;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              illegal_q, illegal_d;
   logic              mem_err_q, mem_err_d;
   logic              is_r, is_ld, is_st, is_cbz, is_bad;
   logic              mem_wait;
   logic              timeout;

   legv8_opcode_decode u_decode (
      .opcode_i  (opcode),
      .is_r_o    (is_r),
      .is_ld_o   (is_ld),
      .is_st_o   (is_st),
      .is_cbz_o  (is_cbz),
      .illegal_o (is_bad)
   );

   assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                      (state_q == S_MEM_WR)) && !mem_ready;
   // wait_q counts cycles already spent waiting, so the limit hits after MEM_TIMEOUT stalls
   assign timeout  = mem_wait && (MEM_TIMEOUT != 0) &&
                     (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         mem_err_q <= mem_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      mem_err_d = mem_err_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (is_r)               state_d = S_EXEC_R;
            else if (is_ld || is_st) state_d = S_ADDR;
            else if (is_cbz)        state_d = S_BRANCH;
            else begin
               state_d   = S_HALT;
               illegal_d = 1'b1;
            end
         end
         S_EXEC_R: state_d = S_WB_R;
         S_WB_R:   state_d = S_FETCH;
         S_ADDR:   state_d = opcode[1] ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: if (mem_ready) state_d = S_WB_LD;
         S_WB_LD:  state_d = S_FETCH;
         S_MEM_WR: if (mem_ready) state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
      if (timeout) begin
         state_d   = S_HALT;
         mem_err_d = 1'b1;
      end
      if (state_d != state_q)
         wait_d = '0;
      else if (mem_wait && (wait_q != '1))
         wait_d = wait_q + 1'b1;
      else
         wait_d = wait_q;
   end

   // Moore decode except the FETCH write pulse (gated by mem_ready) and BRANCH pc_write
   always_comb begin
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg2loc    = 1'b0;
      alu_src_b  = SRCB_REG;
      alu_op     = ALUOP_DTYPE;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = SRCB_BR;
            reg2loc   = is_st || is_cbz;
         end
         S_EXEC_R: alu_op = ALUOP_RTYPE;
         S_WB_R:   reg_write = 1'b1;
         S_ADDR:   alu_src_b = SRCB_OFFS;
         S_MEM_RD: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
         end
         S_WB_LD: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            i_or_d  = 1'b1;
            reg2loc = 1'b1;
         end
         S_BRANCH: begin
            alu_op   = ALUOP_CBZ;
            reg2loc  = 1'b1;
            pc_src   = 1'b1;
            pc_write = zero;
         end
         default: ;
      endcase
   end

   assign illegal = illegal_q;
   assign mem_err = mem_err_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// tb/tb_legv8_multicycle_ctrl.sv - directed self-checking bench for legv8_multicycle_ctrl
module tb_legv8_multicycle_ctrl;

   logic        clk;
   logic        reset;
   logic [10:0] opcode;
   logic        zero;
   logic        mem_ready;
   logic        pc_write, pc_src, ir_write, mem_req, mem_we, i_or_d;
   logic        reg_write, mem_to_reg, reg2loc;
   logic [1:0]  alu_src_b, alu_op;
   logic        illegal, mem_err;
   logic [3:0]  state_o;

   int errors = 0;
   int checks = 0;

   logic [3:0] es [8];
   logic       rd [8];
   logic       pw_c [8], ps_c [8], irw_c [8], rq_c [8], we_c [8], iod_c [8];
   logic       rw_c [8], m2r_c [8], r2l_c [8];
   logic [1:0] aop_c [8], srcb_c [8];

   legv8_multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .ir_write   (ir_write),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .i_or_d     (i_or_d),
      .reg_write  (reg_write),
      .mem_to_reg (mem_to_reg),
      .reg2loc    (reg2loc),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .illegal    (illegal),
      .mem_err    (mem_err),
      .state_o    (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drives op for n cycles using rd[] as mem_ready, checks state against es[], captures outputs
   task automatic run(input string tag, input logic [10:0] op, input int n, input logic z);
      for (int i = 0; i < n; i++) begin
         opcode    = op;
         mem_ready = rd[i];
         zero      = z;
         #1;
         check($sformatf("%s state c%0d", tag, i), 32'(state_o), 32'(es[i]));
         pw_c[i]   = pc_write;   ps_c[i]  = pc_src;  irw_c[i]  = ir_write;
         rq_c[i]   = mem_req;    we_c[i]  = mem_we;  iod_c[i]  = i_or_d;
         rw_c[i]   = reg_write;  m2r_c[i] = mem_to_reg; r2l_c[i] = reg2loc;
         aop_c[i]  = alu_op;     srcb_c[i] = alu_src_b;
         cyc();
      end
   endtask

   initial begin
      reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
      cyc(); cyc();
      check("reset state", 32'(state_o), 32'd0);
      check("reset illegal", 32'(illegal), 32'd0);
      check("reset mem_err", 32'(mem_err), 32'd0);
      check("reset no ir_write", 32'(ir_write), 32'd0);
      reset = 1'b0;

      es = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0};
      rd = '{1, 1, 1, 1, 1, 1, 1, 1};
      run("ADD", 11'b10001011000, 4, 1'b0);
      check("ADD alu_op exec", 32'(aop_c[2]), 32'h2);
      check("ADD srcb exec", 32'(srcb_c[2]), 32'h0);
      check("ADD srcb fetch", 32'(srcb_c[0]), 32'h1);
      check("ADD srcb decode", 32'(srcb_c[1]), 32'h3);
      check("ADD reg_write", 32'({rw_c[0], rw_c[1], rw_c[2], rw_c[3]}), 32'b0001);
      check("ADD pc_write", 32'({pw_c[0], pw_c[1], pw_c[2], pw_c[3]}), 32'b1000);
      check("ADD ir_write", 32'({irw_c[0], irw_c[1], irw_c[2], irw_c[3]}), 32'b1000);
      #1 check("ADD back to fetch", 32'(state_o), 32'd0);
      run("SUB", 11'b11001011000, 4, 1'b0);
      run("AND", 11'b10001010000, 4, 1'b0);
      run("ORR", 11'b10101010000, 4, 1'b0);

      es = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd7};
      rd = '{1, 1, 1, 0, 0, 0, 1, 1};
      run("LDUR", 11'b11111000010, 8, 1'b0);
      check("LDUR mem_req", 32'({rq_c[0], rq_c[1], rq_c[2], rq_c[3], rq_c[4], rq_c[5], rq_c[6], rq_c[7]}), 32'b10011110);
      check("LDUR i_or_d", 32'({iod_c[0], iod_c[1], iod_c[2], iod_c[3], iod_c[4], iod_c[5], iod_c[6], iod_c[7]}), 32'b00011110);
      check("LDUR mem_we", 32'({we_c[3], we_c[4], we_c[5], we_c[6]}), 32'b0000);
      check("LDUR reg_write", 32'({rw_c[0], rw_c[1], rw_c[2], rw_c[3], rw_c[4], rw_c[5], rw_c[6], rw_c[7]}), 32'b00000001);
      check("LDUR mem_to_reg", 32'(m2r_c[7]), 32'd1);
      check("LDUR srcb addr", 32'(srcb_c[2]), 32'h2);
      check("LDUR alu_op addr", 32'(aop_c[2]), 32'h0);
      #1 check("LDUR back to fetch", 32'(state_o), 32'd0);

      es = '{4'd0, 4'd1, 4'd3, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
      rd = '{1, 1, 1, 1, 1, 1, 1, 1};
      run("STUR", 11'b11111000000, 4, 1'b0);
      check("STUR mem_we", 32'({we_c[0], we_c[1], we_c[2], we_c[3]}), 32'b0001);
      check("STUR reg2loc", 32'({r2l_c[0], r2l_c[1], r2l_c[2], r2l_c[3]}), 32'b0101);
      check("STUR reg_write", 32'({rw_c[0], rw_c[1], rw_c[2], rw_c[3]}), 32'b0000);
      #1 check("STUR back to fetch", 32'(state_o), 32'd0);

      es = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      run("CBZ1", 11'b10110100101, 3, 1'b1);
      check("CBZ1 pc_write", 32'({pw_c[0], pw_c[1], pw_c[2]}), 32'b101);
      check("CBZ1 pc_src", 32'({ps_c[0], ps_c[1], ps_c[2]}), 32'b001);
      check("CBZ1 alu_op", 32'(aop_c[2]), 32'h1);
      check("CBZ1 reg2loc", 32'({r2l_c[0], r2l_c[1], r2l_c[2]}), 32'b011);
      run("CBZ0", 11'b10110100010, 3, 1'b0);
      check("CBZ0 pc_write", 32'({pw_c[0], pw_c[1], pw_c[2]}), 32'b100);
      #1 check("CBZ back to fetch", 32'(state_o), 32'd0);

      es = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      run("ILL", 11'b00000000000, 2, 1'b0);
      check("ILL state halt", 32'(state_o), 32'd9);
      check("ILL flag", 32'(illegal), 32'd1);
      for (int i = 0; i < 20; i++) cyc();
      check("ILL still halt", 32'(state_o), 32'd9);
      check("ILL halt mem_req", 32'(mem_req), 32'd0);
      reset = 1'b1;
      cyc();
      check("ILL reset state", 32'(state_o), 32'd0);
      check("ILL reset flag", 32'(illegal), 32'd0);

      reset = 1'b0; mem_ready = 1'b0; opcode = 11'b10001011000;
      for (int i = 0; i < 14; i++) cyc();
      check("TMO still fetch", 32'(state_o), 32'd0);
      check("TMO no err yet", 32'(mem_err), 32'd0);
      check("TMO no ir_write", 32'(ir_write), 32'd0);
      cyc();
      check("TMO halt", 32'(state_o), 32'd9);
      check("TMO mem_err", 32'(mem_err), 32'd1);
      mem_ready = 1'b1;
      cyc();
      check("TMO sticky", 32'(mem_err), 32'd1);
      check("TMO halt held", 32'(state_o), 32'd9);
      reset = 1'b1;
      cyc();
      check("TMO reset err", 32'(mem_err), 32'd0);
      reset = 1'b0;

      es = '{4'd0, 4'd1, 4'd3, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
      rd = '{1, 1, 1, 0, 1, 1, 1, 1};
      run("RSTWR", 11'b11111000000, 4, 1'b0);
      mem_ready = 1'b0;
      #1 check("RSTWR in mem_wr", 32'(state_o), 32'd5);
      reset = 1'b1; mem_ready = 1'b1;
      cyc();
      reset = 1'b0; mem_ready = 1'b0;
      #1;
      check("RSTWR state", 32'(state_o), 32'd0);
      check("RSTWR mem_we", 32'(mem_we), 32'd0);
      cyc();
      check("RSTWR holds fetch", 32'(state_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
